// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state type and the
// tag nibble that marks a header word.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH
    } tx_arb_state_t;

    localparam logic [3:0] TX_ARB_HDR_TAG = 4'hA;

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: picks the first set bit of the valid vector at or
// after the pointer, wrapping from NUM_REQ-1 back to 0.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     idx_o
);

    logic [IDW-1:0] cand;

    // The first hit wins; later candidates are ignored once any_o is set.
    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define TX_ARB_HEADER_EN to prefix every granted word with a header word.
module tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WORD_SIZE = 8,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_ready,
    output logic                          send_valid,
    output logic [WORD_SIZE-1:0]          data_bits,
    output logic                          busy,
    output logic [IDW-1:0]                grant_id
);

    tx_arb_state_t        state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
`ifdef TX_ARB_HEADER_EN
    logic                 hdr_q, hdr_d;
    logic [WORD_SIZE-1:0] payload_q, payload_d;
`endif

    logic                 sel_any;
    logic [NUM_REQ-1:0]   sel_grant;
    logic [IDW-1:0]       sel_idx;
    logic [WORD_SIZE-1:0] sel_word;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_select (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .any_o   (sel_any),
        .grant_o (sel_grant),
        .idx_o   (sel_idx)
    );

    assign sel_word = req_data[int'(sel_idx)*WORD_SIZE +: WORD_SIZE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            grant_q   <= '0;
            data_q    <= '0;
`ifdef TX_ARB_HEADER_EN
            hdr_q     <= 1'b0;
            payload_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
`ifdef TX_ARB_HEADER_EN
            hdr_q     <= hdr_d;
            payload_q <= payload_d;
`endif
        end
    end

    // req_ready is combinational so the requester sees the accept in the
    // same cycle the grant is decided; reset masks it while state is ARB.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        req_ready  = '0;
        send_valid = 1'b0;
`ifdef TX_ARB_HEADER_EN
        hdr_d      = hdr_q;
        payload_d  = payload_q;
`endif
        unique case (state_q)
            ARB: begin
                if (tx_ready && sel_any && !rst) begin
                    req_ready = sel_grant;
                    grant_d   = sel_idx;
`ifdef TX_ARB_HEADER_EN
                    data_d    = {TX_ARB_HDR_TAG, (WORD_SIZE-4)'(sel_idx)};
                    payload_d = sel_word;
                    hdr_d     = 1'b1;
`else
                    data_d    = sel_word;
`endif
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                send_valid = 1'b1;
                state_d    = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!tx_ready) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
`ifdef TX_ARB_HEADER_EN
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        data_d  = payload_q;
                        state_d = ISSUE;
                    end else begin
                        ptr_d   = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
                        state_d = ARB;
                    end
`else
                    ptr_d   = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
                    state_d = ARB;
`endif
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign data_bits = data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ARB);

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: scenario tasks plus a background
// reference model of grant order, transmitted words and busy/strobe timing.
`timescale 1ns/1ps
module tb_tx_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int IDW   = 2;
    localparam int FRAME = 40;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   reqReady;
    logic           txReady;
    logic           sendValid;
    logic [W-1:0]   dataBits;
    logic           busy;
    logic [IDW-1:0] grantId;

    int checks = 0;
    int errors = 0;

    int   txCount = 0;
    logic txHold  = 1'b0;

    int           modelPtr    = 0;
    int           lastGrant   = 0;
    int           grantCount  = 0;
    logic         frameActive = 1'b0;
    logic         sawLow      = 1'b0;
    logic [W-1:0] expQ[$];
    logic [W-1:0] sentQ[$];

    assign txReady = (txCount == 0) && !txHold;

    always #5 clk = ~clk;

    tx_arbiter #(
        .NUM_REQ   (N),
        .WORD_SIZE (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid),
        .req_data   (reqData),
        .req_ready  (reqReady),
        .tx_ready   (txReady),
        .send_valid (sendValid),
        .data_bits  (dataBits),
        .busy       (busy),
        .grant_id   (grantId)
    );

    function automatic int firstValid(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model and reference checker, one step per clock.
    task automatic monitorLoop();
        logic         txAtPos = 1'b1;
        logic         startFrame;
        logic         inTransfer;
        logic         expSend;
        logic [N-1:0] expReady;
        int           idx;
        forever begin
            @(negedge clk);
            startFrame = 1'b0;
            if (rst) begin
                modelPtr    = 0;
                lastGrant   = 0;
                frameActive = 1'b0;
                sawLow      = 1'b0;
                expQ.delete();
            end else begin
                if (frameActive) begin
                    if (!txAtPos) sawLow = 1'b1;
                    else if (sawLow) frameActive = 1'b0;
                end
                inTransfer = frameActive || (expQ.size() != 0);
                expSend    = !frameActive && (expQ.size() != 0);
                idx        = firstValid(reqValid, modelPtr);
                expReady   = '0;
                if (!inTransfer && txReady && idx >= 0) expReady[idx] = 1'b1;

                checks++;
                if (reqReady !== expReady) begin
                    errors++;
                    $display("[TB] FAIL req_ready at %0t: got %b expected %b", $time, reqReady, expReady);
                end
                checks++;
                if (busy !== inTransfer) begin
                    errors++;
                    $display("[TB] FAIL busy at %0t: got %b expected %b", $time, busy, inTransfer);
                end
                checks++;
                if (grantId !== IDW'(lastGrant)) begin
                    errors++;
                    $display("[TB] FAIL grant_id at %0t: got %0d expected %0d", $time, grantId, lastGrant);
                end
                checks++;
                if (sendValid !== expSend) begin
                    errors++;
                    $display("[TB] FAIL send_valid at %0t: got %b expected %b", $time, sendValid, expSend);
                end
                if (expSend) begin
                    checks++;
                    if (dataBits !== expQ[0]) begin
                        errors++;
                        $display("[TB] FAIL data_bits at %0t: got %h expected %h", $time, dataBits, expQ[0]);
                    end
                    sentQ.push_back(dataBits);
                    void'(expQ.pop_front());
                    frameActive = 1'b1;
                    sawLow      = 1'b0;
                    startFrame  = 1'b1;
                end
                if (expReady != '0) begin
                    lastGrant = idx;
                    modelPtr  = (idx + 1) % N;
                    grantCount++;
`ifdef TX_ARB_HEADER_EN
                    expQ.push_back({4'hA, 4'(idx)});
`endif
                    expQ.push_back(reqData[idx*W +: W]);
                end
            end
            @(posedge clk);
            txAtPos = txReady;
            #1;
            if (startFrame) txCount = FRAME;
            else if (txCount > 0) txCount--;
        end
    endtask

    task automatic waitIdle();
        txHold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!frameActive && expQ.size() == 0 && txCount == 0) break;
            tick();
        end
        tick();
    endtask

    task automatic waitGrant(output int idx, output bit ok);
        idx = -1;
        ok  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (reqReady != '0) begin
                for (int k = 0; k < N; k++) if (reqReady[k]) idx = k;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        reqValid = '1;
        reqData  = $urandom;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (reqReady !== '0) begin errors++; $display("[TB] FAIL reset req_ready: got %b expected 0", reqReady); end
        checks++;
        if (sendValid !== 1'b0) begin errors++; $display("[TB] FAIL reset send_valid: got %b expected 0", sendValid); end
        checks++;
        if (dataBits !== '0) begin errors++; $display("[TB] FAIL reset data_bits: got %h expected 00", dataBits); end
        checks++;
        if (grantId !== '0) begin errors++; $display("[TB] FAIL reset grant_id: got %0d expected 0", grantId); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
        tick();
        rst      = 1'b0;
        reqValid = '0;
    endtask

    task automatic test_single();
        int   idx;
        bit   ok;
        int   notBusy = 0;
        bit   sawTxLow = 1'b0;
        logic [W-1:0] expFirst;
`ifdef TX_ARB_HEADER_EN
        expFirst = 8'hA2;
`else
        expFirst = 8'h5A;
`endif
        waitIdle();
        reqData[2*W +: W] = 8'h5A;
        reqValid = 4'b0100;
        waitGrant(idx, ok);
        checks++;
        if (!ok || reqReady !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single grant: got %b (found=%0b) expected 0100", reqReady, ok);
        end
        tick();
        reqValid = '0;
        @(negedge clk);
        checks++;
        if (sendValid !== 1'b1) begin errors++; $display("[TB] FAIL single send_valid: got %b expected 1", sendValid); end
        checks++;
        if (dataBits !== expFirst) begin errors++; $display("[TB] FAIL single data_bits: got %h expected %h", dataBits, expFirst); end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!txReady) sawTxLow = 1'b1;
            if (sawTxLow && txReady) break;
            if (!busy) notBusy++;
        end
        checks++;
        if (!sawTxLow || notBusy != 0) begin
            errors++;
            $display("[TB] FAIL single busy frame: idle cycles %0d (tx seen low=%0b) expected 0", notBusy, sawTxLow);
        end
    endtask

    task automatic test_rotation();
        int idx;
        bit ok;
        waitIdle();
        pulseReset();
        reqValid = '1;
        for (int g = 0; g < 6; g++) begin
            reqData = $urandom;
            waitGrant(idx, ok);
            checks++;
            if (!ok || idx != g % N) begin
                errors++;
                $display("[TB] FAIL rotation grant %0d: got %0d (found=%0b) expected %0d", g, idx, ok, g % N);
            end
            tick();
        end
        reqValid = '0;
    endtask

    task automatic test_wrap();
        int idx;
        bit ok;
        int expSeq[3] = '{3, 0, 3};
        waitIdle();
        reqValid = 4'b1000;
        for (int g = 0; g < 3; g++) begin
            waitGrant(idx, ok);
            checks++;
            if (!ok || idx != expSeq[g]) begin
                errors++;
                $display("[TB] FAIL wrap grant %0d: got %0d (found=%0b) expected %0d", g, idx, ok, expSeq[g]);
            end
            tick();
            reqValid = 4'b1001;
        end
        reqValid = '0;
    endtask

    task automatic test_tx_busy();
        int early = 0;
        waitIdle();
        txHold   = 1'b1;
        reqValid = 4'b0001;
        repeat (6) begin
            @(negedge clk);
            if (reqReady !== '0) early++;
        end
        checks++;
        if (early != 0) begin errors++; $display("[TB] FAIL tx_busy early ready: got %0d pulses expected 0", early); end
        tick();
        txHold = 1'b0;
        @(negedge clk);
        checks++;
        if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL tx_busy release: got %b expected 0001", reqReady); end
        tick();
        reqValid = '0;
    endtask

    task automatic test_reset_mid();
        int idx;
        bit ok;
        waitIdle();
        reqValid = 4'b0010;
        waitGrant(idx, ok);
        tick();
        reqValid = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!txReady) break;
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (reqReady !== '0 || sendValid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset strobes: ready %b send %b busy %b expected 0 0 0", reqReady, sendValid, busy);
        end
        checks++;
        if (dataBits !== '0 || grantId !== '0) begin
            errors++;
            $display("[TB] FAIL midreset regs: data %h grant %0d expected 00 0", dataBits, grantId);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        reqValid = '1;
        waitGrant(idx, ok);
        checks++;
        if (!ok || idx != 0) begin
            errors++;
            $display("[TB] FAIL midreset next grant: got %0d (found=%0b) expected 0", idx, ok);
        end
        tick();
        reqValid = '0;
    endtask

`ifdef TX_ARB_HEADER_EN
    task automatic test_header();
        int pulses = 0;
        waitIdle();
        sentQ.delete();
        reqData[1*W +: W] = 8'h33;
        reqValid = 4'b0010;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (reqReady != '0) pulses++;
            if (sentQ.size() >= 2) break;
        end
        tick();
        reqValid = '0;
        checks++;
        if (pulses != 1) begin errors++; $display("[TB] FAIL header ready pulses: got %0d expected 1", pulses); end
        checks++;
        if (sentQ.size() < 2 || sentQ[0] !== 8'hA1 || sentQ[1] !== 8'h33) begin
            errors++;
            $display("[TB] FAIL header words: got %0d words first %h expected A1 then 33",
                     sentQ.size(), (sentQ.size() > 0) ? sentQ[0] : 8'h00);
        end
    endtask
`endif

    task automatic test_random();
        int startGrants;
        waitIdle();
        startGrants = grantCount;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(3) == 0) reqValid = N'($urandom);
            if ($urandom_range(1) == 0) reqData = $urandom;
            if ($urandom_range(15) == 0) txHold = ~txHold;
        end
        txHold   = 1'b0;
        reqValid = '0;
        checks++;
        if (grantCount - startGrants < 10) begin
            errors++;
            $display("[TB] FAIL random progress: got %0d grants expected at least 10", grantCount - startGrants);
        end
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = '0;
        reqData  = '0;
        fork
            monitorLoop();
        join_none
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_tx_busy();
        test_reset_mid();
`ifdef TX_ARB_HEADER_EN
        test_header();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one transmitter (legal 2..16).
REQ-002 SHALL have parameter WORD_SIZE, default 8, bits per UART word.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester word-pending flag.
REQ-006 SHALL have port req_data  input  NUM_REQ*WORD_SIZE  packed words; requester i occupies bits [i*WORD_SIZE +: WORD_SIZE].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot accept pulse; the word transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port tx_ready  input  1  transmitter idle flag.
REQ-009 SHALL have port send_valid  output  1  one-cycle start strobe to the transmitter.
REQ-010 SHALL have port data_bits  output  WORD_SIZE  word presented to the transmitter, held stable while send_valid is high.
REQ-011 SHALL have port busy  output  1  high in every state except ARB.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the requester most recently granted.

Function
REQ-013 SHALL implement states ARB, ISSUE, WAIT_LOW and WAIT_HIGH.
REQ-014 In ARB with tx_ready=1 and any req_valid bit high, SHALL grant the first valid requester at or after the round-robin pointer (ascending index, wrapping at NUM_REQ-1 to 0).
REQ-015 SHALL drive req_ready[g] high combinationally for exactly that cycle, latch req_data[g] into data_bits, set grant_id=g and move to ISSUE.
REQ-016 In ARB with tx_ready=0 or no request pending, SHALL hold state with req_ready all zero.
REQ-017 In ISSUE, SHALL assert send_valid for exactly one cycle, then move to WAIT_LOW.
REQ-018 In WAIT_LOW, SHALL wait for tx_ready=0, then move to WAIT_HIGH.
REQ-019 In WAIT_HIGH, SHALL wait for tx_ready=1, then set pointer=(g+1) mod NUM_REQ and return to ARB.
REQ-020 SHALL never raise more than one req_ready bit in a cycle, and never raise req_ready outside ARB.
REQ-021 A requester deasserting req_valid before it is granted SHALL lose nothing and SHALL receive no pulse.
REQ-022 Latency from a grant in ARB to send_valid SHALL be exactly 1 cycle; the earliest next grant SHALL come 1 cycle after tx_ready returns high.
REQ-023 With all requesters continuously valid, consecutive grants SHALL follow strict rotation 0,1,2,...,NUM_REQ-1,0.

Reset
REQ-024 While rst=1, SHALL force state=ARB, pointer=0, send_valid=0, req_ready=0, data_bits=0, grant_id=0, busy=0.
REQ-025 Reset asserted mid-transfer SHALL abandon the word without retry; the requester is already acknowledged.

Configuration
REQ-026 When TX_ARB_HEADER_EN is defined, each grant SHALL send two words: first a header {4'hA, grant_id zero-extended to WORD_SIZE-4 bits}, then the data word, each word using its own ISSUE/WAIT_LOW/WAIT_HIGH sequence; the pointer advances only after the data word.
REQ-027 When TX_ARB_HEADER_EN is undefined, SHALL send only the data word and SHALL contain no header logic.

Structure
REQ-028 SHALL take the state enum type tx_arb_state_t and the header nibble constant TX_ARB_HDR_TAG=4'hA from the shared package uart_pkg.
REQ-029 SHALL place the round-robin selection (valid vector plus pointer to one-hot grant and index) in one sub-module, rr_select.

Verification
REQ-030 Single request: NUM_REQ=4, req_valid=4'b0100, req_data[2]=8'h5A, with a transmitter model (4 clk/bit) -> one req_ready[2] pulse, send_valid one cycle later with data_bits=8'h5A, busy for the whole frame.
REQ-031 All valid: req_valid=4'b1111 held for 6 frames -> grant_id sequence 0,1,2,3,0,1.
REQ-032 Pointer wrap: grant 3, then req_valid=4'b1001 -> next grant 0, then 3.
REQ-033 Transmitter busy: tx_ready=0 while req_valid=4'b0001 -> no req_ready until tx_ready=1, then grant on that same cycle.
REQ-034 Reset mid-frame: rst pulsed during WAIT_HIGH -> all outputs at reset values, next grant starts at requester 0.
REQ-035 With TX_ARB_HEADER_EN: requester 1 sends 8'h33 -> tx sends words 8'hA1 then 8'h33, and exactly one req_ready pulse.
